// File: rtl/skip_fetch_stage.sv
// skip_fetch_stage: CAM-based fetch skip lookup with a registered next PC and a valid/ready output stage; the SKIP_STATS_EN macro adds a saturating skip counter.
module skip_fetch_stage #(
    parameter int ENTRIES     = 16,
    parameter int INSTR_SHIFT = 0,
    parameter int BLOCK_IDX   = 0
) (
    input  logic               ClockIn,
    input  logic               AsyncResetIn,
    input  logic               PCValidIn,
    output logic               PCReadyOut,
    input  logic [31:0]        PredictedPCIn,
    output logic               FetchValidOut,
    input  logic               FetchReadyIn,
    output logic [31:0]        NextPCOut,
    output logic               SkipEnOut,
    output logic [3:0]         HitIdxOut,
    output logic [31:0]        SkipEntryOut,
    output logic               Rs1ReadEnOut,
    output logic               Rs2ReadEnOut,
    input  logic [31:0]        RfPtr_SimReg,
    input  logic [ENTRIES-1:0] RB_ValidIn,
    input  logic               FlushIn,
    input  logic               WriteEnIn,
    input  logic [31:0]        WriteAddressIn,
    input  logic [31:0]        WriteDataIn,
    output logic [31:0]        SkipStatOut
);
    localparam int L = $clog2(ENTRIES);
    localparam logic [31:0] ENTRY_MASK = 32'hFFFF_F0FF;

    logic [31:0]        cam_q [ENTRIES];
    logic [31:0]        cam_d [ENTRIES];
    logic [31:0]        ent_q [ENTRIES];
    logic [31:0]        ent_d [ENTRIES];
    logic [ENTRIES-1:0] sts_q, sts_d;
    logic               fv_q, fv_d, skip_q, skip_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]        npc_q, npc_d, entry_q, entry_d;
    logic [3:0]         hit_q, hit_d;

    logic        hit, skip, acc, wr_ok, cmp, ign;
    logic [3:0]  hit_idx, rs1, rs2;
    logic [31:0] entry, target;
    logic [15:0] sts_x, rbv_x;

    assign PCReadyOut    = !fv_q || FetchReadyIn;
    assign acc           = PCValidIn && PCReadyOut && !FlushIn;
    assign wr_ok         = WriteEnIn && ((WriteAddressIn >> (L + 1)) == 32'(BLOCK_IDX));
    assign FetchValidOut = fv_q;
    assign NextPCOut     = npc_q;
    assign SkipEnOut     = skip_q;
    assign HitIdxOut     = hit_q;
    assign SkipEntryOut  = entry_q;
    assign Rs1ReadEnOut  = rs1_q;
    assign Rs2ReadEnOut  = rs2_q;

    // Lookup on the pre-write table: lowest matching valid entry wins, then the skip decision.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        entry   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (cam_q[i] == PredictedPCIn && ent_q[i][31]) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
                entry   = ent_q[i];
            end
        end
        sts_x  = 16'(sts_q);
        rbv_x  = 16'(RB_ValidIn);
        cmp    = entry[30];
        ign    = entry[24];
        rs1    = entry[23:20];
        rs2    = entry[19:16];
        skip   = hit && (cmp ? (sts_x[rs1] && rbv_x[rs1] && (ign || (sts_x[rs2] && rbv_x[rs2])))
                             : RfPtr_SimReg[entry[29:25]]);
        target = PredictedPCIn + (32'(entry[7:0]) << INSTR_SHIFT);
    end

    // Next state: table writes, skip-status update/flush, and the output register handshake.
    always_comb begin
        cam_d   = cam_q;
        ent_d   = ent_q;
        sts_d   = sts_q;
        fv_d    = FlushIn ? 1'b0 : acc ? 1'b1 : FetchReadyIn ? 1'b0 : fv_q;
        npc_d   = acc ? (skip ? target : PredictedPCIn) : npc_q;
        skip_d  = acc ? skip : skip_q;
        hit_d   = acc ? hit_idx : hit_q;
        entry_d = acc ? entry : entry_q;
        rs1_d   = acc ? skip : rs1_q;
        rs2_d   = acc ? (skip && cmp && !ign) : rs2_q;
        if (wr_ok && WriteAddressIn[0])
            ent_d[WriteAddressIn[L:1]] = WriteDataIn & ENTRY_MASK;
        if (wr_ok && !WriteAddressIn[0])
            cam_d[WriteAddressIn[L:1]] = WriteDataIn;
        if (FlushIn)
            sts_d = '0;
        else if (acc && hit)
            sts_d[hit_idx[L-1:0]] = skip;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ClockIn) begin
        if (!AsyncResetIn) begin
            cam_q   <= '{default: '0};
            ent_q   <= '{default: '0};
            sts_q   <= '0;
            fv_q    <= 1'b0;
            npc_q   <= '0;
            skip_q  <= 1'b0;
            hit_q   <= '0;
            entry_q <= '0;
            rs1_q   <= 1'b0;
            rs2_q   <= 1'b0;
        end else begin
            cam_q   <= cam_d;
            ent_q   <= ent_d;
            sts_q   <= sts_d;
            fv_q    <= fv_d;
            npc_q   <= npc_d;
            skip_q  <= skip_d;
            hit_q   <= hit_d;
            entry_q <= entry_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

`ifdef SKIP_STATS_EN
    logic [31:0] stat_q, stat_d;

    // Count accepted skipped lookups, saturating at all-ones.
    always_comb stat_d = (acc && skip && !(&stat_q)) ? stat_q + 32'd1 : stat_q;

    // Counter register; flush does not clear it.
    always_ff @(posedge ClockIn) begin
        if (!AsyncResetIn) stat_q <= '0;
        else stat_q <= stat_d;
    end

    assign SkipStatOut = stat_q;
`else
    assign SkipStatOut = '0;
`endif
endmodule

// File: tb/tb_skip_fetch_stage.sv
// tb_skip_fetch_stage: directed vector table plus hand-written flush, backpressure and reset sequences.
module tb_skip_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, pc_valid, pc_ready, fetch_valid, fetch_ready, skip_en, rs1_en, rs2_en;
    logic        flush, we;
    logic [31:0] pc, npc, entry, rf, wa, wd, stat;
    logic [3:0]  hit;
    logic [15:0] rbv;
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rf;
        logic [15:0] rbv;
        logic [31:0] npc;
        logic        skip;
        logic [3:0]  hit;
        logic [31:0] ent;
        logic        rs2;
    } vec_t;

    vec_t v [13];

    skip_fetch_stage dut (
        .ClockIn(clk), .AsyncResetIn(rst_n), .PCValidIn(pc_valid), .PCReadyOut(pc_ready),
        .PredictedPCIn(pc), .FetchValidOut(fetch_valid), .FetchReadyIn(fetch_ready),
        .NextPCOut(npc), .SkipEnOut(skip_en), .HitIdxOut(hit), .SkipEntryOut(entry),
        .Rs1ReadEnOut(rs1_en), .Rs2ReadEnOut(rs2_en), .RfPtr_SimReg(rf), .RB_ValidIn(rbv),
        .FlushIn(flush), .WriteEnIn(we), .WriteAddressIn(wa), .WriteDataIn(wd), .SkipStatOut(stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic set_entry(input int idx, input logic [31:0] cam, input logic [31:0] w);
        wr(32'(idx * 2), cam);
        wr(32'(idx * 2 + 1), w);
    endtask

    initial begin
        rst_n = 1'b0; pc_valid = 1'b0; fetch_ready = 1'b1; flush = 1'b0; we = 1'b0;
        pc = '0; rf = '0; rbv = '0; wa = '0; wd = '0;
        v[0]  = '{32'h100,      32'h20, 16'h8, 32'h100, 1'b0, 4'd0, 32'h0,        1'b0};
        v[1]  = '{32'h300,      32'h20, 16'h8, 32'h300, 1'b0, 4'd4, 32'hC1300008, 1'b0};
        v[2]  = '{32'h200,      32'h20, 16'h8, 32'h210, 1'b1, 4'd3, 32'h8A000010, 1'b0};
        v[3]  = '{32'h300,      32'h20, 16'h8, 32'h308, 1'b1, 4'd4, 32'hC1300008, 1'b0};
        v[4]  = '{32'h300,      32'h20, 16'h0, 32'h300, 1'b0, 4'd4, 32'hC1300008, 1'b0};
        v[5]  = '{32'h400,      32'h21, 16'h8, 32'h404, 1'b1, 4'd1, 32'h80000004, 1'b0};
        v[6]  = '{32'hFFFFFFF8, 32'h20, 16'h8, 32'h8,   1'b1, 4'd2, 32'h8A000010, 1'b0};
        v[7]  = '{32'h800,      32'h20, 16'hC, 32'h804, 1'b1, 4'd8, 32'hC0320004, 1'b1};
        v[8]  = '{32'h800,      32'h20, 16'h8, 32'h800, 1'b0, 4'd8, 32'hC0320004, 1'b0};
        v[9]  = '{32'h500,      32'h20, 16'h8, 32'h500, 1'b0, 4'd0, 32'h0,        1'b0};
        v[10] = '{32'h700,      32'h20, 16'h8, 32'h700, 1'b0, 4'd7, 32'h80000030, 1'b0};
        v[11] = '{32'h200,      32'h0,  16'h8, 32'h200, 1'b0, 4'd3, 32'h8A000010, 1'b0};
        v[12] = '{32'h300,      32'h0,  16'h8, 32'h300, 1'b0, 4'd4, 32'hC1300008, 1'b0};
        tick(); tick();
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_ready", 32'(pc_ready), 32'd1);
        chk("rst_npc", npc, 32'd0);
        chk("rst_outs", {hit, skip_en, rs1_en, rs2_en}, 32'd0);
        chk("rst_entry", entry, 32'd0);
        chk("rst_stat", stat, 32'd0);
        rst_n = 1'b1;
        set_entry(3, 32'h200, 32'h8A000010);
        set_entry(4, 32'h300, 32'hC1300008);
        set_entry(1, 32'h400, 32'h80000004);
        set_entry(6, 32'h400, 32'h80000020);
        set_entry(2, 32'hFFFFFFF8, 32'h8A000010);
        set_entry(7, 32'h700, 32'h80000F30);
        set_entry(8, 32'h800, 32'hC0320004);
        wr(32'h2A, 32'h500);
        wr(32'h2B, 32'h80000001);
        pc_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            pc = v[i].pc; rf = v[i].rf; rbv = v[i].rbv;
            tick();
            chk($sformatf("v%0d_fv", i), 32'(fetch_valid), 32'd1);
            chk($sformatf("v%0d_npc", i), npc, v[i].npc);
            chk($sformatf("v%0d_skip", i), 32'(skip_en), 32'(v[i].skip));
            chk($sformatf("v%0d_hit", i), 32'(hit), 32'(v[i].hit));
            chk($sformatf("v%0d_entry", i), entry, v[i].ent);
            chk($sformatf("v%0d_rs1", i), 32'(rs1_en), 32'(v[i].skip));
            chk($sformatf("v%0d_rs2", i), 32'(rs2_en), 32'(v[i].rs2));
        end
        pc = 32'h200; rf = 32'h20; rbv = 16'h8;
        tick();
        chk("fl_pre_load", 32'(skip_en), 32'd1);
        pc = 32'h300;
        tick();
        chk("fl_pre_chain", 32'(skip_en), 32'd1);
        flush = 1'b1;
        tick();
        chk("fl_fv", 32'(fetch_valid), 32'd0);
        flush = 1'b0;
        tick();
        chk("fl_after_skip", 32'(skip_en), 32'd0);
        chk("fl_after_hit", 32'(hit), 32'd4);
        pc_valid = 1'b0;
        tick();
        chk("drain_fv", 32'(fetch_valid), 32'd0);
        fetch_ready = 1'b0; pc_valid = 1'b1; pc = 32'h300; rf = 32'h0;
        tick();
        chk("bp_load_hit", 32'(hit), 32'd4);
        pc = 32'h200; rf = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp%0d_ready", i), 32'(pc_ready), 32'd0);
            chk($sformatf("bp%0d_fv", i), 32'(fetch_valid), 32'd1);
            chk($sformatf("bp%0d_npc", i), npc, 32'h300);
            chk($sformatf("bp%0d_hit", i), 32'(hit), 32'd4);
        end
        pc = 32'h300; rf = 32'h0; fetch_ready = 1'b1;
        tick();
        chk("bp_rel_hit", 32'(hit), 32'd4);
        chk("bp_rel_sts", 32'(skip_en), 32'd0);
        pc = 32'h200; rf = 32'h20;
        tick();
        chk("mid_pre_fv", 32'(fetch_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_fv", 32'(fetch_valid), 32'd0);
        chk("mid_npc", npc, 32'd0);
        chk("mid_entry", entry, 32'd0);
        chk("mid_ready", 32'(pc_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("clr_npc", npc, 32'h200);
        chk("clr_hit", 32'(hit), 32'd0);
        pc_valid = 1'b0;
        set_entry(3, 32'h200, 32'h8A000010);
        pc_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        pc_valid = 1'b0;
        tick();
        chk("st_npc", npc, 32'h210);
`ifdef SKIP_STATS_EN
        chk("st_count", stat, 32'd5);
`else
        chk("st_count", stat, 32'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/skip_fetch_stage.md
# skip_fetch_stage

Parametrised, pipelined successor to the fetch-stage skip lookup. Holds a CAM of predicted PCs with skip-table entries and a per-entry skip-status bit, decides each cycle whether the fetched instruction group is skipped, and presents a registered next PC plus register-buffer read enables to decode. It sits between the PC predictor and decode, with valid/ready handshakes on both sides and a memory-mapped table write port.

## Interface
Parameters:
- ENTRIES, 16: table depth; power of two, 2..16.
- INSTR_SHIFT, 0: left shift applied to SkipCount; 0 means byte count, 2 means instruction count.
- BLOCK_IDX, 0: value of the block field that selects this table on the write port.

Ports:
- ClockIn  in  1  clock, all state on rising edge.
- AsyncResetIn  in  1  reset, synchronous, active-low.
- PCValidIn  in  1  predicted PC valid.
- PCReadyOut  out  1  stage can accept a PC.
- PredictedPCIn  in  32  predicted PC.
- FetchValidOut  out  1  output register valid.
- FetchReadyIn  in  1  decode accepts output.
- NextPCOut  out  32  skip target or predicted PC.
- SkipEnOut  out  1  this lookup skipped.
- HitIdxOut  out  4  matched entry index; 0 on miss.
- SkipEntryOut  out  32  raw entry word of the matched entry; 0 on miss.
- Rs1ReadEnOut / Rs2ReadEnOut  out  1 each  RB read enables.
- RfPtr_SimReg  in  32  pointer-register similarity bits.
- RB_ValidIn  in  ENTRIES  RB slot valid, indexed by entry index.
- FlushIn  in  1  pipeline flush.
- WriteEnIn  in  1  table write strobe.
- WriteAddressIn  in  32  word address.
- WriteDataIn  in  32  write data.
- SkipStatOut  out  32  skip counter; see Configuration.

## Operation
- Write decode, with L = log2(ENTRIES):
  - bit0: 0 writes the CAM PC, 1 writes the entry word.
  - bits [L:1]: entry index.
  - bits [31:L+1]: must equal BLOCK_IDX, otherwise the write is ignored.
- Entry word fields:
  - [31] valid
  - [30] type (0 load, 1 compute)
  - [29:25] pointer-register id
  - [24] rs2 ignore
  - [23:20] rs1 index
  - [19:16] rs2 index
  - [15:12] rd index
  - [7:0] SkipCount
  - all other bits stored as 0.
- Lookup is combinational on the current table.
  - Hit when CamPC[i] equals PredictedPCIn and valid[i] is set.
  - Multiple hits: the lowest index wins.
- Skip decision on a hit:
  - Load: skip = RfPtr_SimReg[ptr].
  - Compute: skip = Sts[rs1] & RB_ValidIn[rs1] & (ignore | (Sts[rs2] & RB_ValidIn[rs2])).
  - Miss: skip = 0.
- Target: NextPCOut = PC + (zero-extended SkipCount << INSTR_SHIFT), modulo 2^32 (wraps).
- Read enables: Rs1ReadEnOut = skip; Rs2ReadEnOut = skip & type==compute & !ignore.
- Accept = PCValidIn & PCReadyOut. On accept:
  - Output register loads.
  - On a hit, Sts[hit] is set to the skip decision.
- FlushIn:
  - Clears all Sts bits and FetchValidOut.
  - Blocks that cycle's accept and status update.
  - Has priority over writes to Sts only; table writes proceed.
- Write and lookup in the same cycle: the lookup sees the pre-write table.

## Timing
- Lookup latency is 1 cycle: accepted at edge N, outputs valid after edge N.
- PCReadyOut = !FetchValidOut | FetchReadyIn, combinational.
- Output register holds stable while FetchValidOut & !FetchReadyIn.
- FetchValidOut clears when its output is consumed and nothing new is accepted in that cycle.
- Reset (AsyncResetIn low at an edge):
  - Clears the CAM, all entries (valid=0), Sts, the output register and the counter.
  - All outputs read 0 except PCReadyOut, which reads 1.
  - A mid-stream reset drops the in-flight output.
- Table writes take effect on the edge where WriteEnIn is high and are visible to the next cycle's lookup.

## Configuration
- SKIP_STATS_EN defined:
  - SkipStatOut is a 32-bit counter, incremented on each accepted lookup with skip=1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset; not cleared by flush.
- SKIP_STATS_EN undefined: no counter logic; SkipStatOut is tied to 0.

## Test plan
- Reset, then PC 0x100 with an empty table → after one cycle FetchValidOut=1, NextPCOut=0x100, SkipEnOut=0, HitIdxOut=0.
- Load skip:
  - Setup: entry 3 with CAM 0x200, word 0x8A000010 (valid, load, ptr 5, count 16); RfPtr_SimReg bit5=1; INSTR_SHIFT=0.
  - Response: NextPCOut=0x210, SkipEnOut=1, Rs1ReadEnOut=1, Rs2ReadEnOut=0, HitIdxOut=3.
- Compute chain:
  - Stimulus: entry 4 compute, rs1=3, rs2 ignore, RB_ValidIn[3]=1.
  - Response: skipped only after entry 3 has been skipped; after a FlushIn the same PC gives SkipEnOut=0.
- Backpressure: hold FetchReadyIn=0 for 3 cycles with PCValidIn=1 → outputs stable, PCReadyOut=0, Sts unchanged until release.
- Duplicates and wrap:
  - Entries 1 and 6 both match → HitIdxOut=1.
  - PC 0xFFFFFFF8 with count 16 → NextPCOut=0x00000008.
- Stats/ignored writes:
  - With SKIP_STATS_EN, 5 skipped accepts → SkipStatOut=5.
  - A write with a wrong block field leaves the table unchanged.
